idma_desc64_apb_submitter: RTL

- APB initiator that pushes 64-bit descriptor addresses into the desc64 frontend's DESC_ADDR register.
- Accepts addresses on a valid/ready stream and issues one or two APB write transfers per address, depending on ApbDataWidth.
- Honours wait states from the frontend, which holds pready low while its descriptor FIFO is full.
- Sits on the host/cluster side as a hardware descriptor launcher, for example for a job scheduler or a test sequencer.

---
 rtl/idma_desc64_apb_submitter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/idma_desc64_apb_submitter.sv
// rtl/idma_desc64_apb_submitter.sv - APB initiator writing 64-bit descriptor addresses to DESC_ADDR
module idma_desc64_apb_submitter #(
    parameter int unsigned ApbAddrWidth  = 32,
    parameter int unsigned ApbDataWidth  = 32,
    parameter logic [31:0] DescAddrReg   = 32'h0,
    parameter int unsigned TimeoutCycles = 0,
    parameter int unsigned CntWidth      = 16,
    parameter type apb_req_t = struct packed {
        logic                      psel;
        logic                      penable;
        logic                      pwrite;
        logic [2:0]                pprot;
        logic [ApbAddrWidth-1:0]   paddr;
        logic [ApbDataWidth-1:0]   pwdata;
        logic [ApbDataWidth/8-1:0] pstrb;
    },
    parameter type apb_rsp_t = struct packed {
        logic                    pready;
        logic [ApbDataWidth-1:0] prdata;
        logic                    pslverr;
    }
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [63:0]         desc_addr_i,
    input  logic                desc_valid_i,
    output logic                desc_ready_o,
    output apb_req_t            apb_req_o,
    input  apb_rsp_t            apb_rsp_i,
    output logic                busy_o,
    output logic                error_o,
    output logic [63:0]         err_addr_o,
    output logic                timeout_o,
    input  logic                clear_i,
    output logic [CntWidth-1:0] submitted_cnt_o
);

    if (ApbDataWidth != 32 && ApbDataWidth != 64) begin : g_bad_width
        $error("ApbDataWidth must be 32 or 64");
    end

    localparam int unsigned WaitW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(TimeoutCycles);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e              state_q, state_d;
    logic [63:0]         addr_q;
    logic                beat_q;
    logic [WaitW-1:0]    wait_cnt_q;
    logic [CntWidth-1:0] cnt_q;
    logic                error_q, timeout_q;
    logic [63:0]         err_addr_q;
    logic                accept, next_beat, done_ok, done_err;
    logic                wait_inc, wait_hit;
    logic                unused_rsp;

    assign unused_rsp = ^apb_rsp_i.prdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        desc_ready_o = 1'b0;
        accept       = 1'b0;
        next_beat    = 1'b0;
        done_ok      = 1'b0;
        done_err     = 1'b0;
        case (state_q)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (apb_rsp_i.pready) begin
                    if (apb_rsp_i.pslverr) begin
                        done_err = 1'b1;
                        state_d  = IDLE;
                    end else if (ApbDataWidth == 32 && !beat_q) begin
                        next_beat = 1'b1;
                        state_d   = SETUP;
                    end else begin
                        done_ok = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request is decoded from state so reset drops psel/penable without a clock edge.
    always_comb begin
        apb_req_o = '0;
        if (state_q != IDLE) begin
            apb_req_o.psel    = 1'b1;
            apb_req_o.penable = (state_q == ACCESS);
            apb_req_o.pwrite  = 1'b1;
            apb_req_o.pprot   = 3'b000;
            apb_req_o.paddr   = ApbAddrWidth'(DescAddrReg) + ApbAddrWidth'({beat_q, 2'b00});
            apb_req_o.pwdata  = (ApbDataWidth == 64) ? ApbDataWidth'(addr_q)
                              : ApbDataWidth'(beat_q ? addr_q[63:32] : addr_q[31:0]);
            apb_req_o.pstrb   = '1;
        end
    end

    assign wait_inc = (TimeoutCycles != 0) && (state_q == ACCESS) && !apb_rsp_i.pready
                      && (wait_cnt_q != WaitMax);
    assign wait_hit = wait_inc && (wait_cnt_q == WaitMax - WaitW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            beat_q     <= 1'b0;
            wait_cnt_q <= '0;
            cnt_q      <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= desc_addr_i;
                beat_q <= 1'b0;
            end else if (next_beat) begin
                beat_q <= 1'b1;
            end
            if (state_q == SETUP)  wait_cnt_q <= '0;
            else if (wait_inc)     wait_cnt_q <= wait_cnt_q + WaitW'(1);
            if (done_ok) cnt_q <= cnt_q + CntWidth'(1);
            // A new event wins over a coincident clear.
            if (done_err) begin
                error_q    <= 1'b1;
                err_addr_q <= addr_q;
            end else if (clear_i) begin
                error_q <= 1'b0;
            end
            if (wait_hit)     timeout_q <= 1'b1;
            else if (clear_i) timeout_q <= 1'b0;
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign error_o         = error_q;
    assign err_addr_o      = err_addr_q;
    assign timeout_o       = timeout_q;
    assign submitted_cnt_o = cnt_q;

endmodule
